// File: rtl/lif_layer.sv
// N_CH-channel leaky integrate-and-fire neuron layer with saturating integration,
// configurable reset mode and refractory period. Optional spike counters: LIF_SPIKE_CNT_EN.
module lif_layer #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int REFRAC_W   = 4,
    parameter int THRESH_RST = 200,
    parameter int LEAK_RST   = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [N_CH*W-1:0]     current,
    input  logic                  cfg_we,
    input  logic [W-1:0]          cfg_thresh,
    input  logic [2:0]            cfg_leak,
    input  logic [REFRAC_W-1:0]   cfg_refrac,
    input  logic                  cfg_sub,
`ifdef LIF_SPIKE_CNT_EN
    input  logic                  cnt_clr,
    output logic [N_CH*CNT_W-1:0] spike_cnt,
`endif
    output logic [N_CH*W-1:0]     state,
    output logic [N_CH-1:0]       spike,
    output logic                  spike_any
);

    logic [W-1:0]        thresh_q;
    logic [2:0]          leak_q;
    logic [REFRAC_W-1:0] refrac_q;
    logic                sub_q;

    logic [W-1:0]        state_q [N_CH];
    logic [REFRAC_W-1:0] refr_q  [N_CH];
    logic [N_CH-1:0]     spike_q;

    logic [W-1:0]        decay [N_CH];
    logic [W-1:0]        sat   [N_CH];
    logic [N_CH-1:0]     fire;

    // Per-channel step datapath; all of it reads the registered config, so a
    // config write landing in the same cycle as a step only affects later steps.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            logic [W:0] sum;
            // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
            decay[i] = (32'(leak_q) >= W) ? '0 : (state_q[i] >> leak_q);
            sum      = {1'b0, current[i*W +: W]} + {1'b0, decay[i]};
            sat[i]   = sum[W] ? '1 : sum[W-1:0];
            fire[i]  = (refr_q[i] == '0) && (sat[i] >= thresh_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every channel sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_q <= W'(THRESH_RST);
            leak_q   <= 3'(LEAK_RST);
            refrac_q <= '0;
            sub_q    <= 1'b0;
            spike_q  <= '0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so resetting them is intended.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= '0;
                refr_q[i]  <= '0;
            end
        end else begin
            if (cfg_we) begin
                thresh_q <= cfg_thresh;
                leak_q   <= cfg_leak;
                refrac_q <= cfg_refrac;
                sub_q    <= cfg_sub;
            end
            if (en) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (refr_q[i] != '0) begin
                        // Refractory: leak only, input ignored.
                        refr_q[i]  <= refr_q[i] - 1'b1;
                        state_q[i] <= decay[i];
                        spike_q[i] <= 1'b0;
                    end else if (fire[i]) begin
                        spike_q[i] <= 1'b1;
                        state_q[i] <= sub_q ? (sat[i] - thresh_q) : '0;
                        refr_q[i]  <= refrac_q;
                    end else begin
                        spike_q[i] <= 1'b0;
                        state_q[i] <= sat[i];
                    end
                end
            end else begin
                spike_q <= '0;
            end
        end
    end

    always_comb begin
        state = '0;
        for (int i = 0; i < N_CH; i++) begin
            state[i*W +: W] = state_q[i];
        end
    end

    assign spike     = spike_q;
    assign spike_any = |spike_q;

`ifdef LIF_SPIKE_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];

    // Counts steps that fire; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (fire[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            spike_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_lif_layer.sv
// Directed self-checking bench for lif_layer (default build, spike counters disabled).
module tb_lif_layer;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic [N_CH*W-1:0] current;
    logic              cfg_we;
    logic [W-1:0]      cfg_thresh;
    logic [2:0]        cfg_leak;
    logic [3:0]        cfg_refrac;
    logic              cfg_sub;
    logic [N_CH*W-1:0] state;
    logic [N_CH-1:0]   spike;
    logic              spike_any;

    int checks = 0;
    int errors = 0;

    lif_layer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .current    (current),
        .cfg_we     (cfg_we),
        .cfg_thresh (cfg_thresh),
        .cfg_leak   (cfg_leak),
        .cfg_refrac (cfg_refrac),
        .cfg_sub    (cfg_sub),
        .state      (state),
        .spike      (spike),
        .spike_any  (spike_any)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] st(input int ch);
        return state[ch*W +: W];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        en = 1'b0; cfg_we = 1'b0; current = '0;
        cfg_thresh = '0; cfg_leak = 3'd1; cfg_refrac = '0; cfg_sub = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [W-1:0] c0, c1, c2, c3);
        current = {c3, c2, c1, c0};
    endtask

    task automatic step();
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic cfg(input logic [W-1:0] th, input logic [2:0] lk, input logic [3:0] rf, input logic sb);
        cfg_we = 1'b1; cfg_thresh = th; cfg_leak = lk; cfg_refrac = rf; cfg_sub = sb;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", state); end
        checks++;
        if (spike !== '0 || spike_any !== 1'b0) begin
            errors++; $display("FAIL reset_spike: got %b/%b want 0/0", spike, spike_any);
        end
    endtask

    task automatic test_integrate();
        logic [W-1:0] exp0 [7] = '{8'd101, 8'd151, 8'd176, 8'd189, 8'd195, 8'd198, 8'd0};
        logic [W-1:0] exp1 [9] = '{8'd100, 8'd150, 8'd175, 8'd187, 8'd193, 8'd196, 8'd198, 8'd199, 8'd199};
        do_reset();
        set_cur(8'd101, 8'd100, 8'd0, 8'd0);
        for (int s = 0; s < 9; s++) begin
            step();
            if (s < 7) begin
                checks++;
                if (st(0) !== exp0[s] || spike[0] !== (s == 6)) begin
                    errors++;
                    $display("FAIL integ_ch0 step %0d: got %0d/%b want %0d/%b", s + 1, st(0), spike[0], exp0[s], s == 6);
                end
            end
            checks++;
            if (st(1) !== exp1[s] || spike[1] !== 1'b0) begin
                errors++;
                $display("FAIL integ_ch1 step %0d: got %0d/%b want %0d/0", s + 1, st(1), spike[1], exp1[s]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        // thresh=0 with subtract reset: every channel fires and ch0 keeps 255.
        cfg(8'd0, 3'd1, 4'd0, 1'b1);
        set_cur(8'd255, 8'd0, 8'd0, 8'd0);
        step();
        checks++;
        if (st(0) !== 8'd255 || spike !== 4'b1111) begin
            errors++; $display("FAIL thresh0: got %0d/%b want 255/1111", st(0), spike);
        end
        cfg(8'd255, 3'd1, 4'd0, 1'b0);
        step();
        checks++;
        if (st(0) !== 8'd0 || spike !== 4'b0001 || spike_any !== 1'b1) begin
            errors++; $display("FAIL saturate: got %0d/%b/%b want 0/0001/1", st(0), spike, spike_any);
        end
    endtask

    task automatic test_subtract();
        do_reset();
        cfg(8'd100, 3'd1, 4'd0, 1'b1);
        set_cur(8'd0, 8'd0, 8'd150, 8'd0);
        step();
        checks++;
        if (st(2) !== 8'd50 || spike !== 4'b0100) begin
            errors++; $display("FAIL sub_step1: got %0d/%b want 50/0100", st(2), spike);
        end
        step();
        checks++;
        if (st(2) !== 8'd75 || spike !== 4'b0100) begin
            errors++; $display("FAIL sub_step2: got %0d/%b want 75/0100", st(2), spike);
        end
    endtask

    task automatic test_refractory();
        logic exp_spk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        cfg(8'd200, 3'd1, 4'd2, 1'b0);
        set_cur(8'd0, 8'd0, 8'd0, 8'd250);
        for (int s = 0; s < 4; s++) begin
            step();
            checks++;
            if (spike[3] !== exp_spk[s] || st(3) !== 8'd0) begin
                errors++;
                $display("FAIL refrac step %0d: got %b/%0d want %b/0", s + 1, spike[3], st(3), exp_spk[s]);
            end
        end
    endtask

    task automatic test_idle_and_async_reset();
        do_reset();
        set_cur(8'd101, 8'd0, 8'd0, 8'd0);
        repeat (3) step();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (st(0) !== 8'd176 || spike !== '0) begin
                errors++; $display("FAIL idle cycle %0d: got %0d/%b want 176/0000", k, st(0), spike);
            end
        end
        cfg(8'd100, 3'd1, 4'd0, 1'b0);
        step();
        checks++;
        if (spike_any !== 1'b1 || st(0) !== 8'd0) begin
            errors++; $display("FAIL pre_reset_fire: got %b/%0d want 1/0", spike_any, st(0));
        end
        set_cur(8'd101, 8'd0, 8'd0, 8'd0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state !== '0 || spike !== '0 || spike_any !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %h/%b/%b want 0/0/0", state, spike, spike_any);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // Default threshold must be back: ch0 at 101/step fires only on step 7.
        for (int s = 0; s < 7; s++) begin
            step();
            if (s >= 5) begin
                checks++;
                if (spike[0] !== (s == 6)) begin
                    errors++; $display("FAIL thresh_restored step %0d: got %b want %b", s + 1, spike[0], s == 6);
                end
            end
        end
    endtask

    task automatic test_cfg_same_cycle();
        do_reset();
        set_cur(8'd60, 8'd0, 8'd0, 8'd0);
        cfg_we = 1'b1; cfg_thresh = 8'd50; cfg_leak = 3'd1; cfg_refrac = '0; cfg_sub = 1'b0;
        step();
        cfg_we = 1'b0;
        checks++;
        if (spike[0] !== 1'b0 || st(0) !== 8'd60) begin
            errors++; $display("FAIL cfg_old_used: got %b/%0d want 0/60", spike[0], st(0));
        end
        step();
        checks++;
        if (spike[0] !== 1'b1 || st(0) !== 8'd0) begin
            errors++; $display("FAIL cfg_new_used: got %b/%0d want 1/0", spike[0], st(0));
        end
    endtask

    initial begin
        reset_n = 1'b1;
        en = 1'b0; cfg_we = 1'b0; current = '0;
        cfg_thresh = '0; cfg_leak = 3'd1; cfg_refrac = '0; cfg_sub = 1'b0;
        test_reset();
        test_integrate();
        test_saturate();
        test_subtract();
        test_refractory();
        test_idle_and_async_reset();
        test_cfg_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
